// File: rtl/decoder_scan.sv
// decoder_scan -- registered 1-of-2^SEL_W decoder with active-low outputs
// and an active-low enable, plus an auto-scan mode that walks the outputs
// with a programmable dwell and an optional all-off blanking gap.
// Intended for digit/row selects (7-segment, LED matrix).
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset
//   G_L    in   1      active-low enable
//   mode   in   1      0 = direct decode of A, 1 = auto-scan
//   A      in   SEL_W  direct-mode select address
//   div    in   DIV_W  scan dwell: each output is shown for div+1 cycles
//   Y_L    out  NOUT   active-low one-hot select, registered
//   idx    out  SEL_W  currently selected index, registered
//   frame  out  1      one-cycle pulse when idx wraps NOUT-1 -> 0 while scanning
module decoder_scan #(
  parameter int SEL_W     = 2,
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    G_L,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        A,
  input  logic [DIV_W-1:0]        div,
  output logic [(2**SEL_W)-1:0]   Y_L,
  output logic [SEL_W-1:0]        idx,
  output logic                    frame
);

  localparam int NOUT = 2 ** SEL_W;
  // Blank counter only needs to reach BLANK_CYC-1; keep it at least 1 bit wide.
  localparam int BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BC_W-1:0]  BLANK_LAST = BC_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic             HAS_BLANK  = (BLANK_CYC > 0) ? 1'b1 : 1'b0;
  localparam logic [NOUT-1:0]  ALL_OFF    = {NOUT{1'b1}};
  localparam logic [NOUT-1:0]  ONE_HOT0   = NOUT'(1);
  localparam logic [SEL_W-1:0] LAST_IDX   = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SHOW   = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [DIV_W-1:0]  pcnt_r,  pcnt_s;
  logic [BC_W-1:0]   bcnt_r,  bcnt_s;
  logic [SEL_W-1:0]  idx_r,   idx_s;
  logic [NOUT-1:0]   y_l_r,   y_l_s;
  logic              frame_r, frame_s;
  logic [SEL_W-1:0]  idx_inc_s;

  // Active-low one-hot pattern for a select value.
  function automatic logic [NOUT-1:0] dec_low(input logic [SEL_W-1:0] sel);
    return ~(ONE_HOT0 << sel);
  endfunction

  // Next scan index, wrapping naturally at NOUT.
  assign idx_inc_s = idx_r + SEL_W'(1);

  // Next-state and next-output logic; all outputs are computed here so the
  // registered Y_L always agrees with the registered idx and state.
  always_comb begin
    state_s = state_r;
    pcnt_s  = pcnt_r;
    bcnt_s  = bcnt_r;
    idx_s   = idx_r;
    y_l_s   = y_l_r;
    frame_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!mode) begin
          state_s = ST_DIRECT;
          idx_s   = A;
          y_l_s   = G_L ? ALL_OFF : dec_low(A);
        end else begin
          state_s = ST_SHOW;
          idx_s   = '0;
          pcnt_s  = '0;
          y_l_s   = G_L ? ALL_OFF : dec_low(SEL_W'(0));
        end
      end
      ST_DIRECT: begin
        if (mode) begin
          // Entering scan always starts a fresh frame without pulsing frame.
          state_s = ST_SHOW;
          idx_s   = '0;
          pcnt_s  = '0;
          bcnt_s  = '0;
          y_l_s   = G_L ? ALL_OFF : dec_low(SEL_W'(0));
        end else begin
          idx_s = A;
          y_l_s = G_L ? ALL_OFF : dec_low(A);
        end
      end
      ST_SHOW: begin
        if (!mode) begin
          state_s = ST_DIRECT;
          idx_s   = A;
          pcnt_s  = '0;
          bcnt_s  = '0;
          y_l_s   = G_L ? ALL_OFF : dec_low(A);
        end else if (G_L) begin
          // Disabled: blank the outputs and freeze the scan where it is.
          y_l_s = ALL_OFF;
        end else if (pcnt_r == div) begin
          pcnt_s = '0;
          if (HAS_BLANK) begin
            state_s = ST_BLANK;
            y_l_s   = ALL_OFF;
          end else begin
            idx_s   = idx_inc_s;
            y_l_s   = dec_low(idx_inc_s);
            frame_s = (idx_r == LAST_IDX);
          end
        end else begin
          // Plain increment: a div lowered below pcnt wraps through 2^DIV_W.
          pcnt_s = pcnt_r + DIV_W'(1);
          y_l_s  = dec_low(idx_r);
        end
      end
      ST_BLANK: begin
        if (!mode) begin
          state_s = ST_DIRECT;
          idx_s   = A;
          pcnt_s  = '0;
          bcnt_s  = '0;
          y_l_s   = G_L ? ALL_OFF : dec_low(A);
        end else if (G_L) begin
          y_l_s = ALL_OFF;
        end else if (bcnt_r == BLANK_LAST) begin
          state_s = ST_SHOW;
          bcnt_s  = '0;
          idx_s   = idx_inc_s;
          y_l_s   = dec_low(idx_inc_s);
          frame_s = (idx_r == LAST_IDX);
        end else begin
          bcnt_s = bcnt_r + BC_W'(1);
          y_l_s  = ALL_OFF;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pcnt_s  = '0;
        bcnt_s  = '0;
        idx_s   = '0;
        y_l_s   = ALL_OFF;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pcnt_r  <= '0;
      bcnt_r  <= '0;
      idx_r   <= '0;
      y_l_r   <= ALL_OFF;
      frame_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pcnt_r  <= pcnt_s;
      bcnt_r  <= bcnt_s;
      idx_r   <= idx_s;
      y_l_r   <= y_l_s;
      frame_r <= frame_s;
    end
  end

  assign Y_L   = y_l_r;
  assign idx   = idx_r;
  assign frame = frame_r;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan -- self-checking bench for decoder_scan.
// dut  : SEL_W=2, DIV_W=4, BLANK_CYC=1
// dut0b: SEL_W=2, DIV_W=4, BLANK_CYC=0 (rotation without blanking)
// Expected {Y_L, idx, frame} words are queued when stimulus is applied and
// popped for comparison one clock later, sampled 1 time unit after the edge.
module tb_decoder_scan;

  logic       clk;
  logic       reset;
  logic       G_L;
  logic       mode;
  logic [1:0] A;
  logic [3:0] div;
  logic [3:0] y_a;
  logic [1:0] idx_a;
  logic       frame_a;
  logic [3:0] y_b;
  logic [1:0] idx_b;
  logic       frame_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q [$];

  decoder_scan #(.SEL_W(2), .DIV_W(4), .BLANK_CYC(1)) dut (
    .clk(clk), .reset(reset), .G_L(G_L), .mode(mode), .A(A), .div(div),
    .Y_L(y_a), .idx(idx_a), .frame(frame_a)
  );

  decoder_scan #(.SEL_W(2), .DIV_W(4), .BLANK_CYC(0)) dut0b (
    .clk(clk), .reset(reset), .G_L(G_L), .mode(mode), .A(A), .div(div),
    .Y_L(y_b), .idx(idx_b), .frame(frame_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low one-hot for a 2-bit index.
  function automatic logic [3:0] dec(input logic [1:0] i);
    dec = 4'b1111 ^ (4'b0001 << i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    reset = 1'b1; G_L = 1'b0; mode = 1'b0; A = 2'd0; div = 4'd0;
    #3;
    got = {y_a, idx_a, frame_a};
    n_checks++;
    if (got !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", got, {4'b1111, 2'd0, 1'b0});
    end
    tick();
    tick();
    got = {y_b, idx_b, frame_b};
    n_checks++;
    if (got !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held_noblank: got %b want %b", got, {4'b1111, 2'd0, 1'b0});
    end
    reset = 1'b0;
  endtask

  task automatic test_direct();
    logic [6:0] e;
    logic [6:0] got;
    for (int a = 0; a < 5; a++) begin
      if (a < 4) begin
        A = a[1:0];
        G_L = 1'b0;
        exp_q.push_back({dec(a[1:0]), a[1:0], 1'b0});
      end else begin
        G_L = 1'b1;
        exp_q.push_back({4'b1111, 2'd3, 1'b0});
      end
      tick();
      e = exp_q.pop_front();
      got = {y_a, idx_a, frame_a};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL direct step %0d: got Y_L=%b idx=%0d frame=%b want Y_L=%b idx=%0d frame=%b",
                 a, got[6:3], got[2:1], got[0], e[6:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] e;
    logic [6:0] got;
    int frames = 0;
    mode = 1'b1; div = 4'd2; G_L = 1'b0;
    for (int s = 0; s < 17; s++) begin
      logic [1:0] k;
      k = 2'((s / 4) % 4);
      if (s == 16) exp_q.push_back({4'b1110, 2'd0, 1'b1});
      else if ((s % 4) == 3) exp_q.push_back({4'b1111, k, 1'b0});
      else exp_q.push_back({dec(k), k, 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {y_a, idx_a, frame_a};
      if (frame_a === 1'b1) frames++;
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL scan step %0d: got Y_L=%b idx=%0d frame=%b want Y_L=%b idx=%0d frame=%b",
                 s, got[6:3], got[2:1], got[0], e[6:3], e[2:1], e[0]);
      end
    end
    n_checks++;
    if (frames != 1) begin
      n_fail++;
      $display("FAIL scan_frame_count: got %0d want 1", frames);
    end
  endtask

  task automatic test_pause();
    logic [6:0] e;
    logic [6:0] got;
    // One direct cycle, then rescan with div=5 and a 7-clock disable in idx 1.
    mode = 1'b0; A = 2'd2; G_L = 1'b0;
    exp_q.push_back({4'b1011, 2'd2, 1'b0});
    tick();
    e = exp_q.pop_front();
    got = {y_a, idx_a, frame_a};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL pause_direct: got %b want %b", got, e);
    end
    mode = 1'b1; div = 4'd5;
    for (int n = 0; n < 22; n++) begin
      G_L = (n >= 9 && n <= 15) ? 1'b1 : 1'b0;
      if (n <= 5) exp_q.push_back({4'b1110, 2'd0, 1'b0});
      else if (n == 6) exp_q.push_back({4'b1111, 2'd0, 1'b0});
      else if (n <= 8) exp_q.push_back({4'b1101, 2'd1, 1'b0});
      else if (n <= 15) exp_q.push_back({4'b1111, 2'd1, 1'b0});
      else if (n <= 19) exp_q.push_back({4'b1101, 2'd1, 1'b0});
      else if (n == 20) exp_q.push_back({4'b1111, 2'd1, 1'b0});
      else exp_q.push_back({4'b1011, 2'd2, 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {y_a, idx_a, frame_a};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pause step %0d: got Y_L=%b idx=%0d frame=%b want Y_L=%b idx=%0d frame=%b",
                 n, got[6:3], got[2:1], got[0], e[6:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [6:0] e;
    logic [6:0] got;
    // Finish idx 2 dwell (pcnt 1..5), blank, switch to direct, back to scan.
    for (int n = 0; n < 9; n++) begin
      if (n < 5) exp_q.push_back({4'b1011, 2'd2, 1'b0});
      else if (n == 5) exp_q.push_back({4'b1111, 2'd2, 1'b0});
      else if (n == 6) begin
        mode = 1'b0; A = 2'd3;
        exp_q.push_back({4'b0111, 2'd3, 1'b0});
      end else begin
        mode = 1'b1;
        exp_q.push_back({4'b1110, 2'd0, 1'b0});
      end
      tick();
      e = exp_q.pop_front();
      got = {y_a, idx_a, frame_a};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL mode_switch step %0d: got Y_L=%b idx=%0d frame=%b want Y_L=%b idx=%0d frame=%b",
                 n, got[6:3], got[2:1], got[0], e[6:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] e;
    logic [6:0] got;
    // Rest of idx 0 dwell confirms pcnt restarted at 0 on re-entering scan.
    for (int n = 0; n < 6; n++) begin
      if (n < 4) exp_q.push_back({4'b1110, 2'd0, 1'b0});
      else if (n == 4) exp_q.push_back({4'b1111, 2'd0, 1'b0});
      else exp_q.push_back({4'b1101, 2'd1, 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {y_a, idx_a, frame_a};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pre_reset step %0d: got %b want %b", n, got, e);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    got = {y_a, idx_a, frame_a};
    n_checks++;
    if (got !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_show: got %b want %b", got, {4'b1111, 2'd0, 1'b0});
    end
    #2;
    reset = 1'b0; mode = 1'b1; div = 4'd2; G_L = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (n < 3) exp_q.push_back({4'b1110, 2'd0, 1'b0});
      else if (n == 3) exp_q.push_back({4'b1111, 2'd0, 1'b0});
      else exp_q.push_back({4'b1101, 2'd1, 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {y_a, idx_a, frame_a};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL restart step %0d: got %b want %b", n, got, e);
      end
    end
  endtask

  task automatic test_no_blank();
    logic [6:0] e;
    logic [6:0] got;
    reset = 1'b1;
    tick();
    reset = 1'b0; mode = 1'b1; div = 4'd0; G_L = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [1:0] i;
      i = 2'(k % 4);
      exp_q.push_back({dec(i), i, ((k > 0) && (k % 4 == 0)) ? 1'b1 : 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {y_b, idx_b, frame_b};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL no_blank step %0d: got Y_L=%b idx=%0d frame=%b want Y_L=%b idx=%0d frame=%b",
                 k, got[6:3], got[2:1], got[0], e[6:3], e[2:1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_pause();
    test_mode_switch();
    test_async_reset();
    test_no_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
